nonce_result_checker: RTL

Compares each 256-bit scrypt hash against the share target as the hash leaves `scrypt_top`. A miss asks `main_controller` for the next nonce. A hit queues a 5-byte result frame (header plus winning nonce) for the I2C transceiver's transmit path. The block sits directly downstream of `scrypt_top` inside `scrypt_hasher`, consuming `hash`, `hash_done` and the shared `nonce`.

---
 rtl/scrypt_pkg.sv | 32 +++
 rtl/nonce_result_checker_frame_serializer.sv | 68 ++++++
 rtl/nonce_result_checker.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/scrypt_pkg.sv
// scrypt_pkg
// Shared constants and types for the scrypt hasher result path.
//   HASH_W / NONCE_W      : widths of the scrypt hash and of the nonce
//   RESULT_FRAME_LEN      : bytes in one result frame (header + 4 nonce bytes)
//   DEFAULT_HDR_BYTE      : default first byte of every result frame
//   chk_state_t           : states of the nonce result checker FSM
//   build_result_frame()  : packs header and nonce into a frame, byte 0 in the LSBs
package scrypt_pkg;

    localparam int HASH_W           = 256;
    localparam int NONCE_W          = 32;
    localparam int RESULT_FRAME_LEN = 5;
    localparam int FRAME_W          = RESULT_FRAME_LEN * 8;

    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        MISS = 2'd2,
        SEND = 2'd3
    } chk_state_t;

    // Byte 0 is the header, bytes 1..4 are the nonce little-endian.
    function automatic logic [FRAME_W-1:0] build_result_frame(
        input logic [7:0]         hdr,
        input logic [NONCE_W-1:0] nonce
    );
        return {nonce, hdr};
    endfunction

endpackage

// File: rtl/nonce_result_checker_frame_serializer.sv
// frame_serializer
// Emits a loaded multi-byte frame one byte at a time over a valid/ready
// handshake. A load strobe captures the frame and starts at byte 0; the byte
// counter advances only when tx_valid_o and tx_ready_i are both high, so
// tx_data_o holds through stalls.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (abandons a frame)
//   load_i        : one-cycle strobe, capture frame_i and start sending
//   frame_i       : frame contents, byte 0 in bits [7:0]
//   tx_ready_i    : downstream accepts tx_data_o this cycle
//   tx_data_o     : current frame byte (0 when idle)
//   tx_valid_o    : tx_data_o is valid
//   last_o        : the final byte is being accepted this cycle
module frame_serializer
    import scrypt_pkg::*;
#(
    parameter int FRAME_LEN = RESULT_FRAME_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [FRAME_LEN*8-1:0] frame_i,
    input  logic                   tx_ready_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    output logic                   last_o
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [FRAME_LEN*8-1:0] frame_q;
    logic [CNT_W-1:0]       byte_cnt_q;
    logic                   valid_q;
    logic [7:0]             frame_bytes [FRAME_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_bytes
            assign frame_bytes[gi] = frame_q[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q    <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            frame_q    <= frame_i;
            byte_cnt_q <= '0;
            valid_q    <= 1'b1;
        end else if (valid_q && tx_ready_i) begin
            if (byte_cnt_q == LAST_IDX) begin
                byte_cnt_q <= '0;
                valid_q    <= 1'b0;
            end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
        end
    end

    // Drive zero when idle so a stale nonce never sits on the bus.
    assign tx_data_o  = valid_q ? frame_bytes[byte_cnt_q] : 8'h00;
    assign tx_valid_o = valid_q;
    assign last_o     = valid_q && tx_ready_i && (byte_cnt_q == LAST_IDX);

endmodule

// File: rtl/nonce_result_checker.sv
// nonce_result_checker
// Compares each scrypt hash against the share target, one CMP_W-bit slice per
// cycle starting from the most-significant slice. hash <= target is a hit and
// queues a result frame (header + nonce); a miss pulses next_nonce.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   hash_done      : one-cycle pulse, hash/nonce valid
//   hash, nonce    : scrypt result and the nonce that produced it
//   target         : share target (unsigned)
//   tx_ready       : I2C TX path accepts tx_data
//   tx_data/valid  : result frame byte stream
//   next_nonce     : one-cycle pulse on a miss
//   busy           : FSM not in IDLE
//   overrun        : sticky, hash_done seen while busy
//   clear_overrun  : clears overrun (a simultaneous new overrun wins)
//   hit_count      : saturating hit counter
module nonce_result_checker
    import scrypt_pkg::*;
#(
    parameter int         CMP_W    = 32,
    parameter logic [7:0] HDR_BYTE = DEFAULT_HDR_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hash_done,
    input  logic [HASH_W-1:0]  hash,
    input  logic [NONCE_W-1:0] nonce,
    input  logic [HASH_W-1:0]  target,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               next_nonce,
    output logic               busy,
    output logic               overrun,
    input  logic               clear_overrun,
    output logic [15:0]        hit_count
);

    localparam int NSLICE = HASH_W / CMP_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    chk_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HASH_W-1:0]  hash_q, target_q;
    logic [NONCE_W-1:0] nonce_q;
    logic               overrun_q;
    logic [15:0]        hit_cnt_q;

    logic               capture;
    logic               load_frame;
    logic               frame_last;

    logic [CMP_W-1:0]   hash_sl [NSLICE];
    logic [CMP_W-1:0]   tgt_sl  [NSLICE];
    logic [CMP_W-1:0]   hash_cur, tgt_cur;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slices
            assign hash_sl[gi] = hash_q[gi*CMP_W +: CMP_W];
            assign tgt_sl[gi]  = target_q[gi*CMP_W +: CMP_W];
        end
    endgenerate

    assign hash_cur = hash_sl[idx_q];
    assign tgt_cur  = tgt_sl[idx_q];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        capture    = 1'b0;
        load_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (hash_done) begin
                    capture = 1'b1;
                    idx_d   = IDX_W'(NSLICE - 1);
                    state_d = CMP;
                end
            end
            CMP: begin
                if (hash_cur < tgt_cur) begin
                    state_d    = SEND;
                    load_frame = 1'b1;
                end else if (hash_cur > tgt_cur) begin
                    state_d = MISS;
                end else if (idx_q == '0) begin
                    // Fully equal hash meets the target.
                    state_d    = SEND;
                    load_frame = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            MISS: state_d = IDLE;
            SEND: begin
                if (frame_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Set has priority over clear.
            if (hash_done && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
            if (load_frame && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
        end
    end

    // Operand registers only load on acceptance, so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            hash_q   <= hash;
            target_q <= target;
            nonce_q  <= nonce;
        end
    end

    frame_serializer #(
        .FRAME_LEN (RESULT_FRAME_LEN)
    ) u_frame_serializer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_frame),
        .frame_i    (build_result_frame(HDR_BYTE, nonce_q)),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .last_o     (frame_last)
    );

    assign next_nonce = (state_q == MISS);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign hit_count  = hit_cnt_q;

endmodule
